// File: rtl/moore_10110_pkg.sv
// Shared state encoding for the 10110 serial pattern detectors.
// The behavioural and gate-level versions both rely on these codes.
package moore_10110_pkg;
    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t S1    = 3'd1;
    localparam state_t S10   = 3'd2;
    localparam state_t S101  = 3'd3;
    localparam state_t S1011 = 3'd4;
    localparam state_t FOUND = 3'd5;
endpackage

// File: rtl/moore_10110_gates.sv
// Gate-level twin of moore_10110_detector: hand-derived next-state equations
// over the same encoding (s2 s1 s0); codes 110/111 fall to IDLE.
module moore_10110_gates
    import moore_10110_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    output logic w
);
    state_t state_q;
    logic   s2, s1, s0;
    logic   n2, n1, n0;

    assign s2 = state_q[2];
    assign s1 = state_q[1];
    assign s0 = state_q[0];

    // 011&j -> 100, 100&~j -> 101
    assign n2 = (~s2 &  s1 &  s0 &  j) | (s2 & ~s1 & ~s0 & ~j);
    assign n1 = (~s2 &  s0 & ~j) | (~s2 & s1 & ~s0 & j) | (s2 & ~s1 & s0 & j);
    assign n0 = (~s2 & ~(s1 & s0) & j) | (s2 & ~s1 & (~s0 | j));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= {n2, n1, n0};
    end

    assign w = s2 & ~s1 & s0;
endmodule

// File: rtl/moore_10110_detector.sv
// Moore detector for serial pattern 10110 with overlap.
// w is decoded from the state register only, so j never reaches it combinationally.
module moore_10110_detector
    import moore_10110_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    output logic w
);
    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = j ? S1    : IDLE;
            S1:      state_d = j ? S1    : S10;
            S10:     state_d = j ? S101  : IDLE;
            S101:    state_d = j ? S1011 : S10;
            S1011:   state_d = j ? S1    : FOUND;
            // Trailing "10" of a hit is the start of the next one.
            FOUND:   state_d = j ? S101  : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w = (state_q == FOUND);
    end
endmodule

// File: tb/tb_moore_10110_detector.sv
// Bench for the 10110 detector: directed scenarios plus a random stream, with
// the behavioural and gate versions both checked against a bit-history model.
module tb_moore_10110_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic j   = 1'b0;
    logic w, w_g;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0] hist = '0;
    int         nbits = 0;
    logic       exp_w = 1'b0;

    always #30 clk = ~clk;

    moore_10110_detector dut (.clk(clk), .rst(rst), .j(j), .w(w));
    moore_10110_gates    gte (.clk(clk), .rst(rst), .j(j), .w(w_g));

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One bit per edge: drive on the falling edge, check just after the rising edge.
    task automatic step(input logic jv, input logic rv, input string tag);
        @(negedge clk);
        j   = jv;
        rst = rv;
        @(posedge clk);
        if (rv) begin
            hist  = '0;
            nbits = 0;
        end else begin
            hist  = {hist[3:0], jv};
            nbits = nbits + 1;
        end
        exp_w = (nbits >= 5) && (hist == 5'b10110);
        #1;
        chk({tag, "_w"}, int'(w), int'(exp_w));
        chk({tag, "_wg"}, int'(w_g), int'(exp_w));
    endtask

    task automatic seq(input logic [15:0] bits, input int len, input string tag, output int hits);
        hits = 0;
        for (int i = len - 1; i >= 0; i--) begin
            step(bits[i], 1'b0, tag);
            if (w) hits++;
        end
    endtask

    initial begin
        int hits;

        // Reset, then idle zeros.
        step(1'b0, 1'b1, "reset");
        chk("reset_state", int'(dut.state_q), 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "idle");
        chk("idle_state", int'(dut.state_q), 0);

        // Basic hit, followed by a 0.
        seq(16'b10110, 5, "basic", hits);
        chk("basic_hits", hits, 1);
        step(1'b0, 1'b0, "basic_after");

        // Overlap: two hits in eight bits.
        seq(16'b10110110, 8, "overlap", hits);
        chk("overlap_hits", hits, 2);
        step(1'b0, 1'b0, "ovl_after");

        // Near miss, then completion from the trailing 1.
        seq(16'b101110, 6, "nearmiss", hits);
        chk("nearmiss_hits", hits, 0);
        seq(16'b110, 3, "recover", hits);
        chk("recover_hits", hits, 1);
        step(1'b0, 1'b0, "rec_after");

        // Reset in the middle of a match.
        seq(16'b1011, 4, "partial", hits);
        step(1'b0, 1'b1, "midreset");
        step(1'b0, 1'b0, "post_reset");
        chk("midreset_w", int'(w), 0);
        seq(16'b10110, 5, "after_rst", hits);
        chk("after_rst_hits", hits, 1);

        // Random stream with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(1, 0)), ($urandom_range(49, 0) == 0), "rand");
        end
        // Pattern-heavy random stream to stress overlaps.
        for (int i = 0; i < 60; i++) begin
            int pick = $urandom_range(3, 0);
            case (pick)
                0: seq(16'b10110, 5, "rpat", hits);
                1: seq(16'b110, 3, "rpat", hits);
                2: seq(16'b1011, 4, "rpat", hits);
                default: step(1'($urandom_range(1, 0)), 1'b0, "rpat");
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
